// File: rtl/vrf_read_pipe.sv
// vrf_read_pipe: credit-gated VRF read port over a fixed-latency SRAM, returning
// responses in order through a small circular queue.
module vrf_read_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2,
   parameter int DEPTH        = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  req_ready,
   input  logic                  req_valid,
   input  logic [4:0]            req_bits_vs,
   input  logic [5:0]            req_bits_offset,
   input  logic [3:0]            req_bits_readSource,
   input  logic [2:0]            req_bits_instructionIndex,
   input  logic                  flush,
   output logic                  sram_en,
   output logic [10:0]           sram_addr,
   input  logic [DATA_WIDTH-1:0] sram_rdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_bits_data,
   output logic [3:0]            resp_bits_readSource,
   output logic [2:0]            resp_bits_instructionIndex
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [3:0]            src;
      logic [2:0]            idx;
   } entry_t;
   logic [PW:0] credit_q, credit_d, wr_q, wr_d, rd_q, rd_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [READ_LATENCY-1:0][6:0] tag_q, tag_d;
   entry_t mem_q [DEPTH];
   entry_t head;
   logic accept, fire, push, pop, full;
   // req_ready looks only at registered credits and flush, never at resp_ready
   assign req_ready  = (credit_q < DEPTH_C) & ~flush;
   assign accept     = req_valid & req_ready;
   assign sram_en    = accept;
   assign sram_addr  = {req_bits_vs, req_bits_offset};
   assign resp_valid = wr_q != rd_q;
   assign fire       = resp_valid & resp_ready;
   assign push       = vld_q[READ_LATENCY-1] & ~flush;
   assign pop        = fire & ~flush;
   assign full       = (wr_q[PW] != rd_q[PW]) & (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign head       = mem_q[rd_q[PW-1:0]];
   assign resp_bits_data             = head.data;
   assign resp_bits_readSource       = head.src;
   assign resp_bits_instructionIndex = head.idx;
   always_comb begin
      vld_d    = '0;
      tag_d    = '0;
      vld_d[0] = accept;
      tag_d[0] = {req_bits_readSource, req_bits_instructionIndex};
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
      if (flush) vld_d = '0;
      credit_d = flush ? '0 : credit_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, fire};
      wr_d     = flush ? '0 : wr_q + {{PW{1'b0}}, push};
      rd_d     = flush ? '0 : rd_q + {{PW{1'b0}}, pop};
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         credit_q <= '0;
         vld_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
      end else begin
         credit_q <= credit_d;
         vld_q    <= vld_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
      end
      tag_q <= tag_d;
      if (push) mem_q[wr_q[PW-1:0]] <= {sram_rdata, tag_q[READ_LATENCY-1]};
   end
   // credits bound the in-flight plus queued reads to DEPTH
   assert property (@(posedge clock) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_vrf_read_pipe.sv
// tb_vrf_read_pipe: table-driven single/back-to-back reads, then scoreboarded
// backpressure, streaming, simultaneous, flush and mid-stream reset sequences.
module tb_vrf_read_pipe;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_ready, req_valid = 1'b0, flush = 1'b0;
   logic [4:0]  req_bits_vs = '0;
   logic [5:0]  req_bits_offset = '0;
   logic [3:0]  req_bits_readSource = '0;
   logic [2:0]  req_bits_instructionIndex = '0;
   logic        sram_en;
   logic [10:0] sram_addr;
   logic [31:0] sram_rdata = '0;
   logic        resp_valid, resp_ready = 1'b0;
   logic [31:0] resp_bits_data;
   logic [3:0]  resp_bits_readSource;
   logic [2:0]  resp_bits_instructionIndex;

   vrf_read_pipe dut (
      .clock(clock), .reset(reset), .req_ready(req_ready), .req_valid(req_valid),
      .req_bits_vs(req_bits_vs), .req_bits_offset(req_bits_offset),
      .req_bits_readSource(req_bits_readSource),
      .req_bits_instructionIndex(req_bits_instructionIndex), .flush(flush),
      .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits_data(resp_bits_data),
      .resp_bits_readSource(resp_bits_readSource),
      .resp_bits_instructionIndex(resp_bits_instructionIndex)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic rv; logic [4:0] vs; logic [5:0] off; logic [3:0] src; logic [2:0] idx;
      logic [31:0] rdata; logic rr;
      logic e_rdy; logic e_en; logic [10:0] e_addr; logic e_rv;
      logic [31:0] e_data; logic [3:0] e_src; logic [2:0] e_idx;
   } vec_t;
   typedef struct packed { logic [31:0] d; logic [3:0] s; logic [2:0] i; } rsp_t;

   int checks = 0, errors = 0, nresp = 0, nacc = 0, cred = 0;
   string phase = "init";
   logic [10:0] pa [2];
   rsp_t sbq [$];
   vec_t tv [13];

   function automatic logic [31:0] data_of(input logic [10:0] a);
      return 32'hC0DE_0000 ^ {a, 5'h0, a, 5'h0};
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s_%s act=%h exp=%h", phase, n, act, exp);
      end
   endtask

   // one cycle against the reference model: credits, SRAM return, response order
   task automatic cyc(input logic rv, input logic [4:0] vs, input logic [5:0] off,
                      input logic [3:0] src, input logic [2:0] idx, input logic rr,
                      input logic fl, input int erv);
      logic rdy, acc, f;
      rsp_t e;
      req_valid = rv; req_bits_vs = vs; req_bits_offset = off;
      req_bits_readSource = src; req_bits_instructionIndex = idx;
      resp_ready = rr; flush = fl;
      sram_rdata = data_of(pa[1]);
      #3;
      rdy = (cred < 4) && !fl;
      acc = rv && rdy;
      chk("ready", req_ready, rdy);
      chk("sram_en", sram_en, acc);
      if (acc) chk("sram_addr", sram_addr, {vs, off});
      if (erv >= 0) chk("resp_valid", resp_valid, erv != 0);
      f = resp_valid && rr;
      if (f) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_resp_spurious act=%h exp=none", phase, resp_bits_data);
         end else begin
            e = sbq.pop_front();
            nresp++;
            chk("resp_data", resp_bits_data, e.d);
            chk("resp_src", resp_bits_readSource, e.s);
            chk("resp_idx", resp_bits_instructionIndex, e.i);
         end
      end
      if (fl) begin
         cred = 0;
         sbq.delete();
      end else begin
         cred = cred + int'(acc) - int'(f);
         if (acc) begin
            sbq.push_back({data_of({vs, off}), src, idx});
            nacc++;
         end
      end
      pa[1] = pa[0];
      pa[0] = sram_addr;
      @(posedge clock); #1;
   endtask

   task automatic rst_cycles(input int n);
      reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
      cred = 0;
      sbq.delete();
      pa[0] = '0; pa[1] = '0;
   endtask

   initial begin
      //       rv    vs     off    src    idx   rdata          rr    rdy   en    addr     rv    data           src    idx
      tv[0]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[1]  = '{1'b1, 5'd3,  6'd5,  4'd2,  3'd1, 32'h0,         1'b0, 1'b1, 1'b1, 11'h0C5, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[2]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[3]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[4]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 32'hDEADBEEF,  4'd2,  3'd1};
      tv[5]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 32'hDEADBEEF,  4'd2,  3'd1};
      tv[6]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[7]  = '{1'b1, 5'd31, 6'd63, 4'd15, 3'd7, 32'h0,         1'b1, 1'b1, 1'b1, 11'h7FF, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[8]  = '{1'b1, 5'd0,  6'd1,  4'd4,  3'd2, 32'h0,         1'b1, 1'b1, 1'b1, 11'h001, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[9]  = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h12345678,  1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      tv[10] = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0BADF00D,  1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 32'h12345678,  4'd15, 3'd7};
      tv[11] = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 32'h0BADF00D,  4'd4,  3'd2};
      tv[12] = '{1'b0, 5'd0,  6'd0,  4'd0,  3'd0, 32'h0,         1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 32'h0,         4'd0,  3'd0};
      pa[0] = '0; pa[1] = '0;
      repeat (2) @(posedge clock);
      #1;
      phase = "reset";
      chk("resp_valid", resp_valid, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k < 13; k++) begin
         phase = $sformatf("vec%0d", k);
         req_valid = tv[k].rv; req_bits_vs = tv[k].vs; req_bits_offset = tv[k].off;
         req_bits_readSource = tv[k].src; req_bits_instructionIndex = tv[k].idx;
         sram_rdata = tv[k].rdata; resp_ready = tv[k].rr; flush = 1'b0;
         #3;
         chk("ready", req_ready, tv[k].e_rdy);
         chk("sram_en", sram_en, tv[k].e_en);
         if (tv[k].e_en) chk("sram_addr", sram_addr, tv[k].e_addr);
         chk("resp_valid", resp_valid, tv[k].e_rv);
         if (tv[k].e_rv) begin
            chk("resp_data", resp_bits_data, tv[k].e_data);
            chk("resp_src", resp_bits_readSource, tv[k].e_src);
            chk("resp_idx", resp_bits_instructionIndex, tv[k].e_idx);
         end
         @(posedge clock); #1;
      end

      phase = "backpressure"; nacc = 0; nresp = 0;
      for (int i = 0; i < 8; i++) cyc(1'b1, 5'(i + 1), 6'(i * 3), 4'(i), 3'(i), 1'b0, 1'b0, -1);
      chk("accepts", nacc, 4);
      chk("full_ready", req_ready, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, -1);
      chk("resp_count", nresp, 4);
      chk("sb_left", sbq.size(), 0);

      phase = "stream"; nacc = 0; nresp = 0;
      for (int i = 0; i < 20; i++) cyc(1'b1, 5'(i), 6'(63 - i), 4'(i), 3'(i + 3), 1'b1, 1'b0, -1);
      chk("accepts", nacc, 20);
      for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, -1);
      chk("resp_count", nresp, 20);
      chk("sb_left", sbq.size(), 0);

      phase = "simul"; nacc = 0; nresp = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i + 9), 6'(i), 4'(i + 8), 3'(i), 1'b0, 1'b0, -1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b0, 1'b0, -1);
      cyc(1'b1, 5'd20, 6'd20, 4'd10, 3'd5, 1'b1, 1'b0, 1);
      chk("blocked", nacc, 4);
      cyc(1'b1, 5'd20, 6'd20, 4'd10, 3'd5, 1'b0, 1'b0, 1);
      chk("accepted", nacc, 5);
      for (int i = 0; i < 8; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, -1);
      chk("resp_count", nresp, 5);

      phase = "flush"; nacc = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i + 2), 6'(i + 40), 4'(i + 1), 3'(i + 1), 1'b0, 1'b0, -1);
      cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1);
      nresp = 0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 0);
      cyc(1'b1, 5'd9, 6'd9, 4'd9, 3'd6, 1'b1, 1'b0, 0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, -1);
      chk("resp_count", nresp, 1);

      phase = "midreset"; nacc = 0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 5'(i + 17), 6'(i + 7), 4'(i + 5), 3'(i + 2), 1'b0, 1'b0, -1);
      rst_cycles(2);
      nresp = 0;
      for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 0);
      chk("no_resp", nresp, 0);
      nacc = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i + 1), 6'(i + 50), 4'(i + 3), 3'(i + 4), 1'b0, 1'b0, -1);
      chk("credits_free", nacc, 4);
      for (int i = 0; i < 8; i++) cyc(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, -1);
      chk("resp_count", nresp, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
